// File: rtl/ddr3_multiport_arbiter_if.sv
// ddr3_multiport_arbiter_if: client-side and controller-side signals of the multiport arbiter.
interface ddr3_multiport_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128
);
  logic                        init_done;
  logic [NUM_PORTS-1:0]        p_req;
  logic [NUM_PORTS-1:0]        p_wr;
  logic [NUM_PORTS*ADDR_W-1:0] p_addr;
  logic [NUM_PORTS*5-1:0]      p_bcnt;
  logic [NUM_PORTS-1:0]        p_gnt;
  logic [NUM_PORTS*DATA_W-1:0] p_wdata;
  logic [NUM_PORTS-1:0]        p_wdata_rdy;
  logic [NUM_PORTS-1:0]        p_rvalid;
  logic [DATA_W-1:0]           p_rdata;
  logic [3:0]                  cmd;
  logic                        cmd_valid;
  logic [ADDR_W-1:0]           addr;
  logic [4:0]                  cmd_burst_cnt;
  logic                        cmd_rdy;
  logic                        datain_rdy;
  logic [DATA_W-1:0]           write_data;
  logic                        read_data_valid;
  logic [DATA_W-1:0]           read_data;
  logic                        busy;
  logic                        err_orphan_rd;
  modport slave (
    input  init_done, p_req, p_wr, p_addr, p_bcnt, p_wdata, cmd_rdy, datain_rdy,
           read_data_valid, read_data,
    output p_gnt, p_wdata_rdy, p_rvalid, p_rdata, cmd, cmd_valid, addr, cmd_burst_cnt,
           write_data, busy, err_orphan_rd
  );
  modport master (
    output init_done, p_req, p_wr, p_addr, p_bcnt, p_wdata, cmd_rdy, datain_rdy,
           read_data_valid, read_data,
    input  p_gnt, p_wdata_rdy, p_rvalid, p_rdata, cmd, cmd_valid, addr, cmd_burst_cnt,
           write_data, busy, err_orphan_rd
  );
endinterface

// File: rtl/ddr3_multiport_arbiter.sv
// ddr3_multiport_arbiter: round-robin N-port front end for the DDR3 controller user interface,
// steering write beats to the active writer and routing in-order read beats via a tag FIFO.
module ddr3_multiport_arbiter #(
  parameter int          NUM_PORTS     = 2,
  parameter int          ADDR_W        = 28,
  parameter int          DATA_W        = 128,
  parameter int          BEATS_PER_BST = 2,
  parameter int          RD_TAG_DEPTH  = 8,
  parameter logic [3:0]  CMD_READ      = 4'h1,
  parameter logic [3:0]  CMD_WRITE     = 4'h2
) (
  input logic sclk,
  input logic rst_n,
  ddr3_multiport_arbiter_if.slave bus
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int TW = RD_TAG_DEPTH > 1 ? $clog2(RD_TAG_DEPTH) : 1;
  localparam int BW = $clog2(32 * BEATS_PER_BST + 1);
  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;
  state_t               state;
  logic [1:0]           rst_sync;
  logic                 rst_s_n;
  logic [PW-1:0]        rr, win, pick;
  logic                 wr_l, found, full, empty, accept, push, pop;
  logic [BW-1:0]        beats_l, wcnt, rcnt;
  logic [PW-1:0]        tag_port  [RD_TAG_DEPTH];
  logic [BW-1:0]        tag_beats [RD_TAG_DEPTH];
  logic [TW-1:0]        wp, rp;
  logic [TW:0]          occ;
  logic [NUM_PORTS-1:0] elig;
  function automatic logic [BW-1:0] beats(input logic [4:0] b);
    return BW'({b == 5'd0, b} * BEATS_PER_BST);
  endfunction
  function automatic logic [TW-1:0] nxt(input logic [TW-1:0] p);
    return int'(p) == RD_TAG_DEPTH - 1 ? '0 : p + 1'b1;
  endfunction
  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_s_n = rst_sync[1];
  assign empty  = occ == '0;
  assign full   = occ == (TW+1)'(RD_TAG_DEPTH);
  assign accept = bus.cmd_valid & bus.cmd_rdy;
  assign push   = accept & !wr_l;
  assign pop    = bus.read_data_valid & !empty & (rcnt + 1'b1 == tag_beats[rp]);
  always_comb begin
    elig  = bus.p_req & {NUM_PORTS{bus.init_done}} & (bus.p_wr | {NUM_PORTS{!full}});
    found = 1'b0;
    pick  = rr;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && elig[(int'(rr) + i) % NUM_PORTS]) begin
        found = 1'b1;
        pick  = PW'((int'(rr) + i) % NUM_PORTS);
      end
  end
  assign bus.p_gnt       = accept ? NUM_PORTS'(1) << win : '0;
  assign bus.p_wdata_rdy = (state == WDATA && bus.datain_rdy) ? NUM_PORTS'(1) << win : '0;
  assign bus.write_data  = state == WDATA ? bus.p_wdata[int'(win)*DATA_W +: DATA_W] : '0;
  assign bus.p_rvalid    = (bus.read_data_valid && !empty) ? NUM_PORTS'(1) << tag_port[rp] : '0;
  assign bus.p_rdata     = bus.read_data;
  assign bus.busy        = state != IDLE || !empty;
  always_ff @(posedge sclk or negedge rst_s_n)
    if (!rst_s_n) begin
      state             <= IDLE;
      rr                <= '0;
      win               <= '0;
      wr_l              <= 1'b0;
      beats_l           <= '0;
      wcnt              <= '0;
      rcnt              <= '0;
      wp                <= '0;
      rp                <= '0;
      occ               <= '0;
      bus.cmd_valid     <= 1'b0;
      bus.cmd           <= '0;
      bus.addr          <= '0;
      bus.cmd_burst_cnt <= '0;
      bus.err_orphan_rd <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          win               <= pick;
          wr_l              <= bus.p_wr[pick];
          beats_l           <= beats(bus.p_bcnt[int'(pick)*5 +: 5]);
          bus.cmd           <= bus.p_wr[pick] ? CMD_WRITE : CMD_READ;
          bus.addr          <= bus.p_addr[int'(pick)*ADDR_W +: ADDR_W];
          bus.cmd_burst_cnt <= bus.p_bcnt[int'(pick)*5 +: 5];
          bus.cmd_valid     <= 1'b1;
          state             <= CMD;
        end
        CMD: if (accept) begin
          bus.cmd_valid <= 1'b0;
          rr            <= int'(win) == NUM_PORTS - 1 ? '0 : win + 1'b1;
          state         <= wr_l ? WDATA : IDLE;
        end
        WDATA: if (bus.datain_rdy) begin
          wcnt  <= wcnt + 1'b1 == beats_l ? '0 : wcnt + 1'b1;
          state <= wcnt + 1'b1 == beats_l ? IDLE : WDATA;
        end
        default: state <= IDLE;
      endcase
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      occ <= occ + (TW+1)'(push) - (TW+1)'(pop);
      if (bus.read_data_valid && !empty) rcnt <= pop ? '0 : rcnt + 1'b1;
      if (bus.read_data_valid && empty) bus.err_orphan_rd <= 1'b1;
    end
  always_ff @(posedge sclk)
    if (push) begin
      tag_port[wp]  <= win;
      tag_beats[wp] <= beats_l;
    end
endmodule

// File: tb/tb_ddr3_multiport_arbiter.sv
// tb_ddr3_multiport_arbiter: directed and randomized checks against a transaction-level model
// of round-robin grants, write beat counts and in-order read routing.
module tb_ddr3_multiport_arbiter;
  localparam int N = 2, AW = 28, DW = 128;
  logic sclk = 1'b0, rst_n = 1'b0;
  always #5 sclk = ~sclk;
  ddr3_multiport_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  ddr3_multiport_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .sclk(sclk), .rst_n(rst_n), .bus(bus));
  typedef struct {int port; int left;} rd_t;
  rd_t q[$];
  int errors = 0, checks = 0;
  bit m_pend, m_wr, m_err;
  int m_win, m_rr, m_wleft, m_wport, gport;
  logic [AW-1:0] m_addr;
  logic [4:0] m_bcnt;
  logic [N-1:0] o_gnt, o_wrdy, o_rvalid;
  logic o_cv, o_err, o_busy;
  logic [3:0] o_cmd;
  bit keep, rnd;
  int mode, rdv_mode;
  function automatic int beats(logic [4:0] b);
    return (b == 0 ? 32 : int'(b)) * 2;
  endfunction
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_cmd(int i, bit wr, logic [4:0] b);
    bus.p_req[i] = 1'b1;
    bus.p_wr[i] = wr;
    bus.p_addr[i*AW +: AW] = AW'($urandom);
    bus.p_bcnt[i*5 +: 5] = b;
  endtask
  task automatic new_cmd(int i);
    set_cmd(i, mode == 1 ? 1'b0 : 1'($urandom_range(0, 1)),
            mode == 1 ? 5'd1 : ($urandom_range(0, 15) == 0 ? 5'd0 : 5'($urandom_range(1, 3))));
  endtask
  task automatic mreset();
    q.delete();
    m_pend = 0; m_err = 0; m_rr = 0; m_wleft = 0; m_win = 0; m_wport = 0; gport = -1;
  endtask
  task automatic model_check();
    int occ;
    bit idle;
    logic [N-1:0] exp_rv;
    chk("cmd_valid", bus.cmd_valid, m_pend);
    if (m_pend) begin
      chk("cmd", bus.cmd, m_wr ? 4'h2 : 4'h1);
      chk("addr", bus.addr, m_addr);
      chk("burst_cnt", bus.cmd_burst_cnt, m_bcnt);
    end
    chk("p_gnt", bus.p_gnt, (m_pend && bus.cmd_rdy) ? 1 << m_win : 0);
    chk("p_wdata_rdy", bus.p_wdata_rdy, (m_wleft > 0 && bus.datain_rdy) ? 1 << m_wport : 0);
    if (m_wleft > 0) chk("write_data", bus.write_data, bus.p_wdata[m_wport*DW +: DW]);
    exp_rv = '0;
    if (bus.read_data_valid && q.size() > 0) exp_rv = N'(1 << q[0].port);
    chk("p_rvalid", bus.p_rvalid, exp_rv);
    chk("p_rdata", bus.p_rdata, bus.read_data);
    chk("err_orphan_rd", bus.err_orphan_rd, m_err);
    chk("busy", bus.busy, m_pend || m_wleft > 0 || q.size() > 0);
    o_gnt = bus.p_gnt; o_wrdy = bus.p_wdata_rdy; o_rvalid = bus.p_rvalid;
    o_cv = bus.cmd_valid; o_err = bus.err_orphan_rd; o_busy = bus.busy; o_cmd = bus.cmd;
    idle = !m_pend && m_wleft == 0;
    occ = q.size();
    gport = -1;
    if (m_wleft > 0 && bus.datain_rdy) m_wleft--;
    if (bus.read_data_valid) begin
      if (q.size() > 0) begin
        q[0].left--;
        if (q[0].left == 0) void'(q.pop_front());
      end else m_err = 1;
    end
    if (m_pend && bus.cmd_rdy) begin
      gport = m_win;
      m_rr = (m_win + 1) % N;
      m_pend = 0;
      if (m_wr) begin m_wleft = beats(m_bcnt); m_wport = m_win; end
      else q.push_back('{m_win, beats(m_bcnt)});
    end
    if (idle && bus.init_done)
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (!m_pend && bus.p_req[j] && (bus.p_wr[j] || occ < 8)) begin
          m_pend = 1; m_win = j; m_wr = bus.p_wr[j];
          m_addr = bus.p_addr[j*AW +: AW]; m_bcnt = bus.p_bcnt[j*5 +: 5];
        end
      end
  endtask
  task automatic step();
    @(negedge sclk);
    model_check();
    @(posedge sclk);
    #1;
    for (int i = 0; i < N; i++)
      if (gport == i) begin
        if (keep) new_cmd(i);
        else bus.p_req[i] = 1'b0;
      end
    bus.p_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.read_data = {$urandom, $urandom, $urandom, $urandom};
    if (rnd) begin
      bus.cmd_rdy = $urandom_range(0, 9) < 7;
      bus.datain_rdy = $urandom_range(0, 9) < 7;
      bus.init_done = $urandom_range(0, 9) != 0;
    end
    bus.read_data_valid = rdv_mode == 0 ? 1'b0 :
                          rdv_mode == 1 ? q.size() > 0 : (q.size() > 0 && $urandom_range(0, 9) < 6);
  endtask
  task automatic drain();
    bit done = 0;
    keep = 0; rnd = 0; rdv_mode = 1;
    bus.cmd_rdy = 1; bus.datain_rdy = 1; bus.init_done = 1;
    for (int k = 0; k < 400 && !done; k++) begin
      step();
      done = bus.p_req == '0 && !o_busy && !m_pend;
    end
    chk("drain_done", done, 1);
  endtask
  initial begin
    int cnt, expp;
    bit g;
    bus.init_done = 1; bus.p_req = '0; bus.p_wr = '0; bus.p_addr = '0; bus.p_bcnt = '0;
    bus.p_wdata = '0; bus.cmd_rdy = 0; bus.datain_rdy = 0; bus.read_data_valid = 0; bus.read_data = '0;
    keep = 0; rnd = 0; mode = 0; rdv_mode = 0;
    mreset();
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_orphan_rd, 0);
    chk("rst_gnt", bus.p_gnt, 0);
    rst_n = 1;
    repeat (4) step();
    // single port-0 write, bcnt=1
    bus.cmd_rdy = 1; bus.datain_rdy = 1;
    set_cmd(0, 1, 5'd1);
    step(); chk("t1_cv_latch", o_cv, 0);
    step(); chk("t1_cv", o_cv, 1); chk("t1_cmd", o_cmd, 4'h2); chk("t1_gnt", o_gnt, 2'b01);
    step(); chk("t1_beat0", o_wrdy, 2'b01); chk("t1_gnt_pulse", o_gnt, 0);
    step(); chk("t1_beat1", o_wrdy, 2'b01);
    step(); chk("t1_done_rdy", o_wrdy, 0); chk("t1_done_busy", o_busy, 0);
    // both ports requesting continuously alternate, starting at port 1
    keep = 1; mode = 1; rdv_mode = 1;
    new_cmd(0); new_cmd(1);
    expp = 1; cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_gnt != 0) begin
        chk("t2_alternate", o_gnt, 1 << expp);
        expp ^= 1; cnt++;
      end
    end
    chk("t2_grant_count", cnt, 20);
    drain();
    // tag FIFO fills at 8 outstanding reads
    keep = 1; mode = 1; rdv_mode = 0;
    new_cmd(0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin step(); cnt += int'(o_gnt[0]); end
    chk("t3_eight_granted", cnt, 8);
    chk("t3_busy", o_busy, 1);
    cnt = 0;
    rdv_mode = 1; bus.read_data_valid = 1;
    step(); cnt += int'(o_gnt[0]); chk("t3_rv0", o_rvalid, 2'b01);
    rdv_mode = 0;
    step(); cnt += int'(o_gnt[0]); chk("t3_rv1", o_rvalid, 2'b01);
    for (int k = 0; k < 8; k++) begin step(); cnt += int'(o_gnt[0]); end
    chk("t3_ninth_granted", cnt, 1);
    drain();
    // port 1 bcnt=2 then port 0 bcnt=1, returned in order
    rdv_mode = 0;
    set_cmd(1, 0, 5'd2);
    g = 0;
    for (int k = 0; k < 10 && !g; k++) begin step(); g = o_gnt[1]; end
    chk("t4_gnt1", g, 1);
    set_cmd(0, 0, 5'd1);
    g = 0;
    for (int k = 0; k < 10 && !g; k++) begin step(); g = o_gnt[0]; end
    chk("t4_gnt0", g, 1);
    rdv_mode = 1; bus.read_data_valid = 1;
    for (int k = 0; k < 6; k++) begin step(); chk("t4_route", o_rvalid, k < 4 ? 2'b10 : 2'b01); end
    rdv_mode = 0;
    step(); chk("t4_idle_rv", o_rvalid, 0);
    // orphan read beat
    bus.read_data_valid = 1;
    step(); chk("t5_orphan_rv", o_rvalid, 0); chk("t5_err_pre", o_err, 0);
    step(); chk("t5_err_set", o_err, 1);
    repeat (5) step();
    chk("t5_err_sticky", o_err, 1);
    // reset mid-write after one of two beats
    bus.datain_rdy = 0;
    set_cmd(0, 1, 5'd1);
    g = 0;
    for (int k = 0; k < 10 && !g; k++) begin step(); g = o_gnt[0]; end
    chk("t6_gnt", g, 1);
    bus.datain_rdy = 1;
    step(); chk("t6_beat0", o_wrdy, 2'b01);
    bus.datain_rdy = 0;
    rst_n = 0;
    #1;
    chk("t6_rst_cv", bus.cmd_valid, 0);
    chk("t6_rst_wrdy", bus.p_wdata_rdy, 0);
    chk("t6_rst_wdata", bus.write_data, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_err", bus.err_orphan_rd, 0);
    chk("t6_rst_cmd", bus.cmd, 0);
    mreset();
    step(); step();
    rst_n = 1;
    repeat (3) step();
    bus.datain_rdy = 1;
    set_cmd(0, 1, 5'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step(); cnt += int'(o_wrdy[0]); end
    chk("t6_rewrite_beats", cnt, 2);
    chk("t6_rewrite_idle", o_busy, 0);
    // randomized traffic on both ports
    rnd = 1; mode = 0; keep = 1; rdv_mode = 2;
    new_cmd(0); new_cmd(1);
    for (int k = 0; k < 2000; k++) begin
      rdv_mode = (k >= 500 && k < 700) ? 0 : 2;
      step();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
